stream_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one forward-registered valid/ready output stage among N

---
 rtl/stream_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/stream_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbitration blocks.
package stream_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr_i, wrapping modulo N.
module rr_pick
  import stream_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           any_o
);

  logic [IDW-1:0] pos_s;

  // Scan from the pointer and keep the first hit.
  always_comb begin
    gnt_idx_o = {IDW{1'b0}};
    any_o     = 1'b0;
    pos_s     = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      pos_s = IDW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[pos_s]) begin
        any_o     = 1'b1;
        gnt_idx_o = pos_s;
      end else begin
        gnt_idx_o = gnt_idx_o;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one forward-registered output stage;
// each beat is tagged with its source index.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int L   = 8,
  localparam int IDW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_valid,
  output logic [N-1:0]   s_ready,
  input  logic [N*L-1:0] s_data,
  input  logic [N-1:0]   s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [L-1:0]   m_data,
  output logic           m_last,
  output logic [IDW-1:0] m_id
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic           m_valid_q, m_valid_d;
  logic [L-1:0]   m_data_q, m_data_d;
  logic           m_last_q, m_last_d;
  logic [IDW-1:0] m_id_q, m_id_d;

  logic [IDW-1:0] pick_idx_s;
  logic           pick_any_s;
  logic [IDW-1:0] sel_s;
  logic           cand_s;
  logic           load_s;
  logic           xfer_s;
  logic [L-1:0]   sel_data_s;
  logic           sel_last_s;
  logic [N-1:0]   s_ready_s;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(N - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return idx + IDW'(1);
    end
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req_i     (s_valid),
    .ptr_i     (ptr_q),
    .gnt_idx_o (pick_idx_s),
    .any_o     (pick_any_s)
  );

  // Source selection and the upstream handshake.
  always_comb begin
    load_s = m_ready | ~m_valid_q;
    if (state_q == LOCKED) begin
      sel_s  = owner_q;
      cand_s = 1'b1;
    end else begin
      sel_s  = pick_idx_s;
      cand_s = pick_any_s;
    end

    sel_data_s = {L{1'b0}};
    sel_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_s == IDW'(i)) begin
        sel_data_s = s_data[i*L +: L];
        sel_last_s = s_last[i];
      end else begin
        sel_data_s = sel_data_s;
      end
    end

    // No beat is accepted while reset is held, so upstream never loses one.
    s_ready_s = {N{1'b0}};
    if (load_s && cand_s && rst) begin
      s_ready_s[sel_s] = 1'b1;
    end else begin
      s_ready_s = {N{1'b0}};
    end
    xfer_s = s_valid[sel_s] & s_ready_s[sel_s];
  end

  assign s_ready = s_ready_s;

  // Output-slice and arbitration next state.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;

    if (load_s) begin
      if (xfer_s) begin
        m_valid_d = 1'b1;
        m_data_d  = sel_data_s;
        m_last_d  = sel_last_s;
        m_id_d    = sel_s;
      end else begin
        m_valid_d = 1'b0;
      end
    end else begin
      m_valid_d = m_valid_q;
    end

    // ptr only advances at packet end, bounding how long a pending request waits.
    case (state_q)
      IDLE: begin
        if (xfer_s && sel_last_s) begin
          ptr_d = next_idx(sel_s);
        end else if (xfer_s) begin
          state_d = LOCKED;
          owner_d = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && sel_last_s) begin
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {IDW{1'b0}};
        owner_d = {IDW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= {IDW{1'b0}};
      owner_q   <= {IDW{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= {L{1'b0}};
      m_last_q  <= 1'b0;
      m_id_q    <= {IDW{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: a reference arbiter predicts grants and
// pushes expected beats, which are popped as the DUT presents them.
module tb_stream_rr_arbiter;

  localparam int N     = 4;
  localparam int L     = 8;
  localparam int IDW   = 2;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [L-1:0]   data;
    logic           last;
  } beat_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*L-1:0] s_data;
  logic [N-1:0]   s_last;
  logic           m_valid;
  logic           m_ready;
  logic [L-1:0]   m_data;
  logic           m_last;
  logic [IDW-1:0] m_id;

  stream_rr_arbiter #(.N(N), .L(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_id    (m_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [L:0]   src_mem [N][DEPTH];
  int           src_hd [N];
  int           src_tl [N];
  bit           src_en [N];
  logic [N-1:0] vld;
  logic [L-1:0] data_seq;

  int    md_ptr;
  int    md_owner;
  bit    md_locked;
  bit    md_mvalid;
  beat_t exp_q[$];
  int    out_ids[$];
  int    pop_cyc[$];
  int    cyc;
  int    n_checks;
  int    n_errs;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int r, input int beats);
    for (int b = 0; b < beats; b++) begin
      src_mem[r][src_tl[r]] = {(b == beats - 1), data_seq};
      data_seq = data_seq + 8'd1;
      src_tl[r]++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      vld[i] = src_en[i] && (src_hd[i] < src_tl[i]);
      if (src_hd[i] < src_tl[i]) begin
        s_data[i*L +: L] = src_mem[i][src_hd[i]][L-1:0];
        s_last[i]        = src_mem[i][src_hd[i]][L];
      end else begin
        s_data[i*L +: L] = 8'h00;
        s_last[i]        = 1'b0;
      end
    end
    s_valid = vld;
  endtask

  function automatic bit pending();
    bit p;
    p = md_mvalid || (exp_q.size() != 0);
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && (src_hd[i] < src_tl[i])) p = 1'b1;
    end
    return p;
  endfunction

  // One clock: starts and ends at a falling edge.
  task automatic cycle();
    bit           load;
    bit           cand;
    bit           xfer;
    int           sel;
    logic [N-1:0] rdy_exp;
    beat_t        b;
    drive_inputs();
    #1;
    load = m_ready || !md_mvalid;
    cand = 1'b0;
    sel  = 0;
    if (md_locked) begin
      sel  = md_owner;
      cand = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!cand && vld[(md_ptr + k) % N]) begin
          cand = 1'b1;
          sel  = (md_ptr + k) % N;
        end
      end
    end
    rdy_exp = (load && cand) ? (4'b0001 << sel) : 4'b0000;
    xfer    = load && cand && vld[sel];
    check_val("s_ready", 32'(s_ready), 32'(rdy_exp));
    check_val("m_valid", 32'(m_valid), 32'(md_mvalid));
    if (md_mvalid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        check_val("m_id",   32'(m_id),   32'(exp_q[0].id));
        check_val("m_data", 32'(m_data), 32'(exp_q[0].data));
        check_val("m_last", 32'(m_last), 32'(exp_q[0].last));
        if (m_ready) begin
          out_ids.push_back(int'(m_id));
          pop_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    if (load) md_mvalid = xfer;
    if (xfer) begin
      b.id   = IDW'(sel);
      b.data = src_mem[sel][src_hd[sel]][L-1:0];
      b.last = src_mem[sel][src_hd[sel]][L];
      exp_q.push_back(b);
      src_hd[sel]++;
      if (b.last) begin
        md_locked = 1'b0;
        md_ptr    = (sel + 1) % N;
      end else begin
        md_locked = 1'b1;
        md_owner  = sel;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check_val("drain_done", 32'(pending()), 32'd0);
  endtask

  task automatic check_ids(input string tag, input string s, input bit contig);
    check_val({tag, "_len"}, 32'(out_ids.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < out_ids.size(); i++) begin
      check_val({tag, "_id"}, 32'(out_ids[i]), 32'(int'(s.getc(i)) - 48));
    end
    if (contig && pop_cyc.size() == s.len()) begin
      check_val({tag, "_rate"}, 32'(pop_cyc[$] - pop_cyc[0]), 32'(s.len() - 1));
    end
    out_ids.delete();
    pop_cyc.delete();
  endtask

  // Hold reset for n cycles from a falling edge, then release it at a falling edge.
  task automatic hold_reset(input int n);
    rst       = 1'b0;
    md_ptr    = 0;
    md_owner  = 0;
    md_locked = 1'b0;
    md_mvalid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      #1;
      check_val("rst_m_valid", 32'(m_valid), 32'd0);
      check_val("rst_s_ready", 32'(s_ready), 32'd0);
      check_val("rst_m_id",    32'(m_id),    32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    cyc       = 0;
    rst       = 1'b0;
    m_ready   = 1'b1;
    s_valid   = 4'b0000;
    s_data    = 32'h0;
    s_last    = 4'b0000;
    vld       = 4'b0000;
    data_seq  = 8'h10;
    md_ptr    = 0;
    md_owner  = 0;
    md_locked = 1'b0;
    md_mvalid = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_en[i] = 1'b1;
      src_hd[i] = 0;
      src_tl[i] = 0;
    end

    // Reset with everyone requesting, then two rounds of single-beat packets.
    for (int i = 0; i < N; i++) add_pkt(i, 1);
    for (int i = 0; i < N; i++) add_pkt(i, 1);
    @(negedge clk);
    hold_reset(3);
    drain(40);
    check_ids("rr_single", "01230123", 1'b1);

    // Multi-beat packet holds the output against a competing requester.
    add_pkt(1, 3);
    add_pkt(2, 1);
    drain(40);
    check_ids("lock", "1112", 1'b1);

    // Backpressure on a held beat.
    add_pkt(0, 3);
    cycle();
    m_ready = 1'b0;
    repeat (5) cycle();
    m_ready = 1'b1;
    drain(40);
    check_ids("bp", "000", 1'b0);

    // Pointer wrap: after req3 finishes, req0 beats req2.
    add_pkt(3, 1);
    drain(40);
    add_pkt(0, 1);
    add_pkt(2, 1);
    drain(40);
    check_ids("wrap", "302", 1'b0);

    // Lock bubble: owner pauses, nobody else is granted.
    add_pkt(1, 3);
    cycle();
    src_en[1] = 1'b0;
    add_pkt(3, 1);
    cycle();
    cycle();
    drive_inputs();
    #1;
    check_val("bubble_m_valid", 32'(m_valid), 32'd0);
    check_val("bubble_ready3", 32'(s_ready[3]), 32'd0);
    src_en[1] = 1'b1;
    drain(40);
    check_ids("bubble", "1113", 1'b0);

    // Reset in the middle of a req2 packet.
    add_pkt(2, 4);
    cycle();
    cycle();
    check_ids("pre_rst", "2", 1'b0);
    rst = 1'b0;
    #1;
    check_val("rst_async_m_valid", 32'(m_valid), 32'd0);
    src_hd[2] = src_tl[2];
    add_pkt(0, 1);
    add_pkt(2, 2);
    @(negedge clk);
    hold_reset(2);
    drain(40);
    check_ids("post_rst", "022", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
